// File: rtl/bitserial_logic_unit.sv
// Bit-serial two-operand logic unit. Each bit is computed twice: once with a
// behavioural expression and once through a NOR-only network. The unit reports whether the two ever disagreed.

module bitserial_logic_nor (
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  logic na_w, nb_w, nor_w, or_w, and_w, nand_w;
  logic t1_w, t2_w, xnor_w, xor_w, pass_w;

  assign na_w   = ~(a | a);
  assign nb_w   = ~(b | b);
  assign nor_w  = ~(a | b);
  assign or_w   = ~(nor_w | nor_w);
  assign and_w  = ~(na_w | nb_w);
  assign nand_w = ~(and_w | and_w);
  // t1 = ~a & b, t2 = a & ~b; NOR of the two terms gives XNOR
  assign t1_w   = ~(a | nor_w);
  assign t2_w   = ~(b | nor_w);
  assign xnor_w = ~(t1_w | t2_w);
  assign xor_w  = ~(xnor_w | xnor_w);
  assign pass_w = ~(na_w | na_w);

  always_comb begin
    y = pass_w;
    case (mode)
      3'd0: y = and_w;
      3'd1: y = or_w;
      3'd2: y = nand_w;
      3'd3: y = nor_w;
      3'd4: y = xor_w;
      3'd5: y = xnor_w;
      3'd6: y = na_w;
      3'd7: y = pass_w;
      default: y = pass_w;
    endcase
  end
endmodule

module bitserial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             mismatch
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [2:0]       mode_q, mode_d;
  logic             acc_q, acc_d, zero_q, zero_d, mis_q, mis_d;

  logic             a_bit, b_bit, beh_bit, nor_bit, last_bit;
  logic [WIDTH-1:0] sr_next;
  logic             acc_next;

  assign a_bit    = a_q[idx_q];
  assign b_bit    = b_q[idx_q];
  assign last_bit = (idx_q == IW'(WIDTH - 1));

  bitserial_logic_nor u_nor (
    .mode (mode_q),
    .a    (a_bit),
    .b    (b_bit),
    .y    (nor_bit)
  );

  always_comb begin
    beh_bit = a_bit;
    case (mode_q)
      3'd0: beh_bit = a_bit & b_bit;
      3'd1: beh_bit = a_bit | b_bit;
      3'd2: beh_bit = ~(a_bit & b_bit);
      3'd3: beh_bit = ~(a_bit | b_bit);
      3'd4: beh_bit = a_bit ^ b_bit;
      3'd5: beh_bit = ~(~a_bit ^ ~b_bit);
      3'd6: beh_bit = ~a_bit;
      3'd7: beh_bit = a_bit;
      default: beh_bit = a_bit;
    endcase
  end

  // LSB-first: new bits enter at the top, so after WIDTH shifts bit 0 sits at [0]
  assign sr_next  = {beh_bit, sr_q[WIDTH-1:1]};
  assign acc_next = acc_q | (beh_bit != nor_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      sr_q     <= '0;
      acc_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Result registers load on the last RUN edge so they are visible in DONE
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    mis_d    = mis_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          mode_d = mode;
          idx_d  = '0;
          sr_d   = '0;
          acc_d  = 1'b0;
        end
      end
      S_RUN: begin
        sr_d  = sr_next;
        acc_d = acc_next;
        if (last_bit) begin
          result_d = sr_next;
          zero_d   = (sr_next == '0);
          mis_d    = acc_next;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign mismatch = mis_q;
endmodule

// File: tb/tb_bitserial_logic_unit.sv
// Directed bench for bitserial_logic_unit: a timeline/word-level model checked every cycle, plus literal expectations.

module tb_bitserial_logic_unit;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, zero, mismatch;
  logic [7:0] result;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic fault_job = 1'b0;

  bitserial_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] golden(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y);
    case (m)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age = edges since the accepting edge, saturating at WIDTH+1 (idle)
  int         age = WIDTH + 1;
  logic [7:0] p_res = 8'h00, m_res = 8'h00;
  logic       p_flt = 1'b0, m_zero = 1'b1, m_mis = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age    <= WIDTH + 1;
      m_res  <= 8'h00;
      m_zero <= 1'b1;
      m_mis  <= 1'b0;
    end else begin
      if (age == WIDTH + 1 && start) begin
        age   <= 0;
        p_res <= golden(mode, a, b);
        p_flt <= fault_job;
      end else if (age < WIDTH + 1) begin
        age <= age + 1;
      end
      if (age == WIDTH - 1) begin
        m_res  <= p_res;
        m_zero <= (p_res == 8'h00);
        m_mis  <= p_flt;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, age < WIDTH);
      check("done", done, age == WIDTH);
      check("result", result, m_res);
      check("zero", zero, m_zero);
      check("mismatch", mismatch, m_mis);
      check("busy_and_done", busy & done, 1'b0);
    end
  end

  task automatic drive_start(input logic [2:0] m, input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk); #1;
    start = 1'b1; mode = m; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed, output int nbusy);
    int lat;
    nbusy = 0;
    lat = 0;
    for (int i = elapsed + 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = i; break; end
    end
    check("done_latency", lat, WIDTH + 1);
  endtask

  logic [7:0] mode_exp [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};

  initial begin
    int nb, dcnt, lat;
    logic [7:0] r_done;
    logic b10;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_result", result, 8'h00);
    check("reset_zero", zero, 1'b1);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    drive_start(3'd5, 8'hA5, 8'h0F);
    wait_done(0, nb);
    check("xnor_busy_cycles", nb, 8);
    check("xnor_result", result, 8'h55);
    check("xnor_zero", zero, 1'b0);
    check("xnor_mismatch", mismatch, 1'b0);

    drive_start(3'd4, 8'hA5, 8'h0F);
    wait_done(0, nb);
    check("xor_result", result, 8'hAA);

    for (int m = 0; m < 8; m++) begin
      drive_start(3'(m), 8'hF0, 8'h3C);
      wait_done(0, nb);
      check($sformatf("mode%0d_result", m), result, mode_exp[m]);
      check($sformatf("mode%0d_mismatch", m), mismatch, 1'b0);
    end

    drive_start(3'd4, 8'h3C, 8'h3C);
    wait_done(0, nb);
    check("xor_self_result", result, 8'h00);
    check("xor_self_zero", zero, 1'b1);
    drive_start(3'd3, 8'h00, 8'h00);
    wait_done(0, nb);
    check("nor_zero_result", result, 8'hFF);
    check("nor_zero_zero", zero, 1'b0);

    // start held high and operands disturbed during RUN
    @(posedge clk); #1;
    start = 1'b1; mode = 3'd0; a = 8'hFF; b = 8'h81;
    @(posedge clk); #1;
    mode = 3'd7; a = 8'h00; b = 8'hFF;
    dcnt = 0; lat = 0; r_done = 8'h00; b10 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (lat == 0) begin lat = i; r_done = result; end
      end
      if (i == 10) b10 = busy;
    end
    start = 1'b0;
    check("busystart_done_count", dcnt, 1);
    check("busystart_latency", lat, WIDTH + 1);
    check("busystart_result", r_done, 8'h81);
    check("busystart_idle_before_e10", b10, 1'b0);
    wait_done(2, nb);
    check("busystart_second_result", result, 8'h00);
    check("busystart_second_zero", zero, 1'b1);

    // reset in the middle of a job
    drive_start(3'd5, 8'hA5, 8'h0F);
    wait_done(0, nb);
    check("pre_reset_result", result, 8'h55);
    drive_start(3'd0, 8'hFF, 8'hFF);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_result", result, 8'h00);
    check("midreset_zero", zero, 1'b1);
    check("midreset_done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("postreset_no_done", dcnt, 0);
    drive_start(3'd1, 8'h01, 8'h80);
    wait_done(0, nb);
    check("postreset_result", result, 8'h81);

    // one forced NOR node during bit 5 of an AND job
    fault_job = 1'b1;
    drive_start(3'd0, 8'hFF, 8'h0F);
    repeat (5) begin @(posedge clk); #1; end
    force dut.u_nor.and_w = 1'b1;
    @(posedge clk); #1;
    release dut.u_nor.and_w;
    wait_done(6, nb);
    check("fault_mismatch", mismatch, 1'b1);
    check("fault_result", result, 8'h0F);
    fault_job = 1'b0;
    drive_start(3'd0, 8'hFF, 8'h0F);
    wait_done(0, nb);
    check("clean_mismatch", mismatch, 1'b0);
    check("clean_result", result, 8'h0F);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/bitserial_logic_unit.md
# bitserial_logic_unit

Parametrised bit-serial two-operand logic unit. It evaluates one of eight bitwise functions over WIDTH-bit operands, one bit per clock, LSB first. Every bit is computed twice, once with a behavioural expression and once with a NOR-only gate network, and the unit flags any disagreement between the two. It is the clocked, multi-mode, multi-bit successor to the team's single-bit NOR-only function checks and sits as a self-checking logic stage in the lab datapath.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a job; sampled only in IDLE
- mode  input  3  function select, latched with start
- a  input  WIDTH  operand A, latched with start
- b  input  WIDTH  operand B, latched with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result is updated
- result  output  WIDTH  last completed result
- zero  output  1  result == 0, updated with result
- mismatch  output  1  behavioural and NOR-only paths disagreed on at least one bit of the last job

## Operation

- Modes:
  - 0: AND
  - 1: OR
  - 2: NAND
  - 3: NOR
  - 4: XOR
  - 5: XNOR, the same function as ~(~a ^ ~b)
  - 6: NOT a
  - 7: PASS a
- NOR-only path: each mode is built solely from 2-input NOR primitives (NOT = nor(x,x)). It is a separate structural submodule, instantiated once and fed the current bit pair.
- FSM states and transitions:
  - IDLE: start=1 -> RUN; latch a, b and mode; bit index = 0; clear the internal mismatch accumulator.
  - RUN: each cycle computes bit[index] on both paths, shifts the behavioural bit into the internal shift register and ORs (behavioural != NOR) into the accumulator. When index == WIDTH-1 -> DONE; otherwise index+1.
  - DONE: copy the shift register to result, set zero and mismatch, assert done, then -> IDLE.
- start is ignored in RUN and DONE, with no queuing. Operand and mode changes after the latch edge have no effect on the running job.
- result, zero and mismatch hold their values until the next DONE or reset.
- Reset values, applied asynchronously: state IDLE; busy 0; done 0; result 0; zero 1; mismatch 0; index 0; shift register 0.

## Timing

- Edge E0: start=1 is sampled in IDLE; busy goes high after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH-1.
- After E_WIDTH the state is DONE. busy drops, done=1, and result, zero and mismatch take their new values in this same cycle.
- After E_WIDTH+1 the state is IDLE and done=0.
- Latency: result is valid WIDTH+1 cycles after the edge that accepted start. busy is high for exactly WIDTH cycles.
- Throughput: one job per WIDTH+2 cycles. The earliest next acceptance is the edge that ends DONE... no: it is the first edge after returning to IDLE, at E_WIDTH+2.
- Reset mid-job aborts immediately. Partial bits are discarded and the previous result is not preserved, because reset clears it. The first start after reset deasserts behaves normally.
- busy and done are never high together.

## Test plan

- Reset, then WIDTH=8, mode 5, a=8'hA5, b=8'h0F, pulse start:
  - busy high for 8 cycles.
  - done pulses at cycle 9.
  - result=8'h55, zero=0, mismatch=0.
  - A repeat with mode 4 gives 8'hAA.
- All modes with a=8'hF0, b=8'h3C, each checked against the golden function:
  - AND=8'h30, OR=8'hFC, NAND=8'hCF, NOR=8'h03.
  - XOR=8'hCC, XNOR=8'h33, NOT a=8'h0F, PASS=8'hF0.
  - mismatch=0 throughout.
- Mode 4 with a=b=8'h3C -> result=8'h00, zero=1. Then mode 3 with a=b=0 -> result=8'hFF, zero=0.
- Busy-start test:
  - Start a job with mode 0, a=8'hFF, b=8'h81.
  - Hold start=1 and change a, b and mode during RUN.
  - Only one done occurs; result=8'h81; the next job starts only at E10 or later.
- Reset test:
  - After a completed job with result=8'h55, start a new job and assert reset at cycle 4.
  - busy=0, result=0 and zero=1 immediately; no done pulse appears.
  - A following job with mode 1, a=8'h01, b=8'h80 gives 8'h81.
- Fault injection: force one internal NOR output of the NOR-only path for a single bit. The completed job reports mismatch=1 with the behavioural result unchanged, and the next clean job reports mismatch=0.
